// File: rtl/async_fifo_param.sv
// async_fifo_param: dual-clock FIFO. Pointers cross clock domains only in Gray
// code. Flags, fill levels and pulses are all registered. Each domain has its
// own reset synchronizer, so each side leaves reset cleanly on its own clock.
// SYNC_STAGES is expected to be in the range 2..4.
module async_fifo_param #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = (1 << ADDR_W) - 2,
    parameter int AEMPTY_TH   = 2
) (
    input  logic              wr_clk,
    input  logic              wr_rst,
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_count,
    output logic              overflow,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_count,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AFULL_LIM  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_LIM = (ADDR_W+1)'(AEMPTY_TH);
    // The write pointer is one lap ahead of the read pointer when the two top
    // Gray bits differ and the other bits match.
    localparam logic [ADDR_W:0] FULL_MASK  = (ADDR_W+1)'(3) << (ADDR_W - 1);

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_W-1:0] memQ [DEPTH];

    logic [1:0]      wrRstSyncQ;
    logic            wrRstN;
    logic [ADDR_W:0] wrBinQ, wrBinD, wrGrayQ, wrGrayD;
    logic [ADDR_W:0] rdGraySyncQ [SYNC_STAGES];
    logic [ADDR_W:0] rdGrayInWr;
    logic [ADDR_W:0] wrCountQ, wrCountD;
    logic            fullQ, fullD, almostFullQ, almostFullD, overflowQ, overflowD;
    logic            wrAccept;

    logic [1:0]      rdRstSyncQ;
    logic            rdRstN;
    logic [ADDR_W:0] rdBinQ, rdBinD, rdGrayQ, rdGrayD;
    logic [ADDR_W:0] wrGraySyncQ [SYNC_STAGES];
    logic [ADDR_W:0] wrGrayInRd;
    logic [ADDR_W:0] rdCountQ, rdCountD;
    logic            emptyQ, emptyD, almostEmptyQ, almostEmptyD, underflowQ, underflowD;
    logic            rdValidQ;
    logic            rdAccept;
    logic [DATA_W-1:0] rdDataQ;

    // Write-domain reset: asserts immediately, releases after two wr_clk edges.
    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) wrRstSyncQ <= 2'b00;
        else         wrRstSyncQ <= {wrRstSyncQ[0], 1'b1};
    end
    assign wrRstN = wrRstSyncQ[1];

    // Read-domain reset: asserts immediately, releases after two rd_clk edges.
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) rdRstSyncQ <= 2'b00;
        else         rdRstSyncQ <= {rdRstSyncQ[0], 1'b1};
    end
    assign rdRstN = rdRstSyncQ[1];

    assign rdGrayInWr = rdGraySyncQ[SYNC_STAGES-1];
    assign wrGrayInRd = wrGraySyncQ[SYNC_STAGES-1];

    // Write side next state: accept, advance pointer, and look ahead for full/level.
    always_comb begin
        wrAccept    = wr_en & ~fullQ;
        wrBinD      = wrBinQ + (ADDR_W+1)'(wrAccept);
        wrGrayD     = bin2gray(wrBinD);
        fullD       = (wrGrayD == (rdGrayInWr ^ FULL_MASK));
        wrCountD    = wrBinD - gray2bin(rdGrayInWr);
        almostFullD = (wrCountD >= AFULL_LIM);
        overflowD   = wr_en & fullQ;
    end

    // Write side state registers plus the read-pointer synchronizer chain.
    always_ff @(posedge wr_clk or negedge wrRstN) begin
        if (!wrRstN) begin
            wrBinQ      <= '0;
            wrGrayQ     <= '0;
            fullQ       <= 1'b0;
            almostFullQ <= 1'b0;
            wrCountQ    <= '0;
            overflowQ   <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) rdGraySyncQ[i] <= '0;
        end else begin
            wrBinQ      <= wrBinD;
            wrGrayQ     <= wrGrayD;
            fullQ       <= fullD;
            almostFullQ <= almostFullD;
            wrCountQ    <= wrCountD;
            overflowQ   <= overflowD;
            rdGraySyncQ[0] <= rdGrayQ;
            for (int i = 1; i < SYNC_STAGES; i++) rdGraySyncQ[i] <= rdGraySyncQ[i-1];
        end
    end

    // Storage is never reset; only accepted writes touch it.
    always_ff @(posedge wr_clk) begin
        if (wrAccept && wrRstN) memQ[wrBinQ[ADDR_W-1:0]] <= wr_data;
    end

    // Read side next state: accept, advance pointer, and look ahead for empty/level.
    always_comb begin
        rdAccept     = rd_en & ~emptyQ;
        rdBinD       = rdBinQ + (ADDR_W+1)'(rdAccept);
        rdGrayD      = bin2gray(rdBinD);
        emptyD       = (rdGrayD == wrGrayInRd);
        rdCountD     = gray2bin(wrGrayInRd) - rdBinD;
        almostEmptyD = (rdCountD <= AEMPTY_LIM);
        underflowD   = rd_en & emptyQ;
    end

    // Read side state registers, output data register and write-pointer synchronizer.
    always_ff @(posedge rd_clk or negedge rdRstN) begin
        if (!rdRstN) begin
            rdBinQ       <= '0;
            rdGrayQ      <= '0;
            emptyQ       <= 1'b1;
            almostEmptyQ <= 1'b1;
            rdCountQ     <= '0;
            underflowQ   <= 1'b0;
            rdValidQ     <= 1'b0;
            rdDataQ      <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) wrGraySyncQ[i] <= '0;
        end else begin
            rdBinQ       <= rdBinD;
            rdGrayQ      <= rdGrayD;
            emptyQ       <= emptyD;
            almostEmptyQ <= almostEmptyD;
            rdCountQ     <= rdCountD;
            underflowQ   <= underflowD;
            rdValidQ     <= rdAccept;
            if (rdAccept) rdDataQ <= memQ[rdBinQ[ADDR_W-1:0]];
            wrGraySyncQ[0] <= wrGrayQ;
            for (int i = 1; i < SYNC_STAGES; i++) wrGraySyncQ[i] <= wrGraySyncQ[i-1];
        end
    end

    assign full         = fullQ;
    assign almost_full  = almostFullQ;
    assign wr_count     = wrCountQ;
    assign overflow     = overflowQ;
    assign rd_data      = rdDataQ;
    assign rd_valid     = rdValidQ;
    assign empty        = emptyQ;
    assign almost_empty = almostEmptyQ;
    assign rd_count     = rdCountQ;
    assign underflow    = underflowQ;
endmodule

// File: doc/async_fifo_param.md
ASYNC_FIFO_PARAM -- requirements
Module: async_fifo_param

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 8, data width in bits.
- ADDR_W, default 4, address width; depth = 2^ADDR_W.
- SYNC_STAGES, default 2, pointer synchronizer depth; legal range 2..4.
- AFULL_TH, default 2^ADDR_W-2, almost_full threshold in entries.
- AEMPTY_TH, default 2, almost_empty threshold in entries.
REQ-002 Ports SHALL be:
- wr_clk  in  1  write clock.
- wr_rst  in  1  write-domain reset, asynchronous, active-low.
- rd_clk  in  1  read clock.
- rd_rst  in  1  read-domain reset, asynchronous, active-low.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- full  out  1  FIFO full.
- almost_full  out  1  wr_count >= AFULL_TH.
- wr_count  out  ADDR_W+1  write-side fill level.
- overflow  out  1  one-cycle pulse on a rejected write.
- rd_en  in  1  read request.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  rd_data holds newly popped data this cycle.
- empty  out  1  FIFO empty.
- almost_empty  out  1  rd_count <= AEMPTY_TH.
- rd_count  out  ADDR_W+1  read-side fill level.
- underflow  out  1  one-cycle pulse on a rejected read.

Function
REQ-003 Each reset SHALL pass through an internal 2-flop synchronizer: assertion is asynchronous, deassertion takes effect after 2 edges of the local clock.
REQ-004 Pointers SHALL be ADDR_W+1 bits wide, kept in binary and Gray. Gray = bin ^ (bin>>1). Both forms are registered.
REQ-005 Only Gray pointers SHALL cross domains, through SYNC_STAGES flops clocked and reset by the destination domain.
REQ-006 A write SHALL be accepted at a wr_clk rising edge when wr_en=1 and full=0. Accepted write: mem[wr_bin[ADDR_W-1:0]] <= wr_data, then wr_bin increments modulo 2^(ADDR_W+1).
REQ-007 full SHALL be registered. It is 1 when the next write Gray pointer equals the synced read Gray pointer with its two MSBs inverted and the remaining bits equal.
REQ-008 Full timing:
- full SHALL assert on the same edge that accepts the write filling the last entry.
- full SHALL deassert no later than SYNC_STAGES+2 wr_clk edges after the read that frees an entry.
REQ-009 A read SHALL be accepted at a rd_clk rising edge when rd_en=1 and empty=0. Accepted read: rd_data <= mem[rd_bin[ADDR_W-1:0]], rd_valid=1 for exactly that next cycle, rd_bin increments.
REQ-010 When no read is accepted, rd_data SHALL hold its value and rd_valid SHALL be 0.
REQ-011 empty SHALL be registered. It is 1 when the next read Gray pointer equals the synced write Gray pointer.
REQ-012 Empty timing:
- empty SHALL assert on the edge that pops the last entry.
- empty SHALL deassert no later than SYNC_STAGES+2 rd_clk edges after the first accepted write.
REQ-013 Fill levels SHALL be registered modulo-2^(ADDR_W+1) differences:
- wr_count = next wr_bin - binary(synced rd Gray).
- rd_count = binary(synced wr Gray) - next rd_bin.
- Both are pessimistic: wr_count never under-reports and rd_count never over-reports the true occupancy.
REQ-014 almost_full and almost_empty SHALL be registered in the same cycle as their counts.
REQ-015 overflow SHALL pulse for 1 wr_clk when wr_en=1 and full=1. The write is dropped and no state changes.
REQ-016 underflow SHALL pulse for 1 rd_clk when rd_en=1 and empty=1. No state changes.
REQ-017 Simultaneous write and read in the same period SHALL both be accepted if individually legal. Occupancy is unchanged.
REQ-018 Wrap-around SHALL be seamless: throughput and flags are unaffected when pointers pass 2^(ADDR_W+1)-1 to 0.
REQ-019 Memory SHALL be a non-reset register array of 2^ADDR_W x DATA_W.

Reset
REQ-020 While wr_rst=0, the write domain SHALL hold: write pointers and rd-pointer synchronizer = 0, full=0, almost_full=0, wr_count=0, overflow=0.
REQ-021 While rd_rst=0, the read domain SHALL hold: read pointers and wr-pointer synchronizer = 0, empty=1, almost_empty=1, rd_count=0, rd_data=0, rd_valid=0, underflow=0.
REQ-022 A mid-operation flush SHALL assert wr_rst and rd_rst together, each for at least 2 cycles of its own clock. After both deassert, the FIFO SHALL be empty and contents are discarded.

Verification
REQ-023 Fill: defaults, wr_clk 100 MHz, rd_clk 37 MHz, write 0x01..0x10 with no reads -> full=1 on the 16th write edge, almost_full=1 at wr_count=14, a 17th write gives overflow pulse and data is not stored.
REQ-024 Drain: from full, read 16 times -> rd_data 0x01..0x10 in order with rd_valid each, empty=1 on the 16th pop, a 17th rd_en gives underflow pulse and rd_data stays 0x10.
REQ-025 Streaming: random wr_en/rd_en for 10000 writes with clock ratio swept 1:3 to 3:1 -> scoreboard order exact, no overflow/underflow when requests are gated by the flags, pointers wrap at least 300 times.
REQ-026 Latency: single write into an empty FIFO -> empty deasserts within SYNC_STAGES+2 rd_clk edges. Repeat with SYNC_STAGES=3.
REQ-027 Reset: assert both resets with 9 entries stored -> all REQ-020/021 values within one clock of assertion. After release, write 0xA5 -> first read returns 0xA5.
REQ-028 Parameters: DATA_W=32, ADDR_W=6, AFULL_TH=60, AEMPTY_TH=4 -> full at 64 entries, almost_full at 60, almost_empty while rd_count <= 4.
